// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
//
// Shares one single-port instruction BRAM (1-cycle read latency) between the
// fetch stage and a PS-side program loader. It also sequences boot: the core
// is held in BOOT while the loader fills memory, and released into RUN on
// ldr_done. In RUN the core has priority. A wait counter bounds how long the
// loader can be starved before it preempts the core.
//
// Parameters
//   ADDR_W     BRAM word-address width (depth = 2**ADDR_W words)
//   MAX_WAIT   loader wait cycles before it preempts the core (0 = loader always wins)
//   BOOT_HOLD  1: reset enters BOOT (core held), 0: reset enters RUN
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   core_req/core_pc    fetch read request and byte address (word = pc[ADDR_W+1:2])
//   core_gnt/core_stall fetch read issued this cycle / fetch must hold its PC
//   core_rvalid/rdata   fetch read data, valid one cycle after core_gnt
//   core_run            core may execute (0 while in BOOT)
//   ldr_req/we/addr/wdata  loader access, held stable until ldr_gnt
//   ldr_done/ldr_boot   pulses: BOOT->RUN / RUN->BOOT (reload)
//   ldr_gnt             loader access issued this cycle
//   ldr_rvalid/rdata    loader read data, valid one cycle after a granted read
//   mem_*               BRAM port (mem_rdata valid the cycle after mem_en)
//
// Optional build macro
//   IMEM_ARB_PERF_EN    adds perf_stall_cnt (core_stall cycles in RUN) and
//                       perf_steal_cnt (loader grants taken while core_req in RUN)
// ---------------------------------------------------------------------------
module imem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int MAX_WAIT  = 8,
    parameter int BOOT_HOLD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic [31:0]       core_pc,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [31:0]       core_rdata,
    output logic              core_run,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [31:0]       ldr_wdata,
    input  logic              ldr_done,
    input  logic              ldr_boot,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [31:0]       ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_steal_cnt
`endif
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A counter that only has to hold 0 still needs one bit.
    localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
    localparam state_t RESET_STATE = (BOOT_HOLD != 0) ? ST_BOOT : ST_RUN;

    state_t          state;
    logic [WCW-1:0]  wait_cnt;
    logic [ADDR_W-1:0] core_word;

    // Byte offset and address bits above the BRAM depth are ignored, so the
    // fetch address simply wraps around the memory.
    assign core_word = core_pc[ADDR_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{core_pc[31:ADDR_W+2], core_pc[1:0]};

    // ------------------------------------------------------------------
    // Grant selection: at most one requester owns the BRAM per cycle.
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        core_gnt = 1'b0;
        ldr_gnt  = 1'b0;
        if (state == ST_BOOT) begin
            ldr_gnt = ldr_req;
        end else if (ldr_req && (wait_cnt == WAIT_MAX)) begin
            ldr_gnt = 1'b1;          // starvation bound reached: loader preempts
        end else if (core_req) begin
            core_gnt = 1'b1;
        end else begin
            ldr_gnt = ldr_req;
        end
    end

    assign core_stall = core_req & ~core_gnt;
    assign core_run   = (state == ST_RUN);

    // BRAM port: address is forced to zero when idle so the bus is quiet.
    assign mem_en    = core_gnt | ldr_gnt;
    assign mem_we    = ldr_gnt & ldr_we;
    assign mem_addr  = core_gnt ? core_word :
                       ldr_gnt  ? ldr_addr  : '0;
    assign mem_wdata = ldr_wdata;

    assign core_rdata = mem_rdata;
    assign ldr_rdata  = mem_rdata;

    // ------------------------------------------------------------------
    // Boot/run state, loader wait counter, read-valid tracking.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RESET_STATE;
            wait_cnt    <= '0;
            core_rvalid <= 1'b0;       // a read in flight at reset is dropped
            ldr_rvalid  <= 1'b0;
        end else begin
            core_rvalid <= core_gnt;
            ldr_rvalid  <= ldr_gnt & ~ldr_we;   // writes return no data
            case (state)
                ST_BOOT: begin
                    wait_cnt <= '0;
                    if (ldr_done) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Reload request wins; ldr_done is meaningless in RUN.
                    if (ldr_boot) begin
                        state <= ST_BOOT;
                    end
                    if (ldr_gnt) begin
                        wait_cnt <= '0;
                    end else if (ldr_req && (wait_cnt != WAIT_MAX)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= RESET_STATE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef IMEM_ARB_PERF_EN
    // Performance counters, RUN only; both wrap naturally at 2**32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_steal_cnt <= '0;
        end else if (state == ST_RUN) begin
            if (core_stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (ldr_gnt && core_req) begin
                perf_steal_cnt <= perf_steal_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_arbiter
//
// Self-checking bench for imem_arbiter (ADDR_W=12, MAX_WAIT=8, BOOT_HOLD=1)
// with a behavioural 1-cycle-latency BRAM. Boot load, core streaming,
// priority, idle bus, wrap addressing and read-after-write are covered by a
// vector table; starvation bound, reload and reset corners are hand-written.
// ---------------------------------------------------------------------------
module tb_imem_arbiter;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_req;
    logic [31:0]       core_pc;
    logic              core_gnt, core_stall, core_rvalid, core_run;
    logic [31:0]       core_rdata;
    logic              ldr_req, ldr_we, ldr_done, ldr_boot;
    logic [ADDR_W-1:0] ldr_addr;
    logic [31:0]       ldr_wdata;
    logic              ldr_gnt, ldr_rvalid;
    logic [31:0]       ldr_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;
`ifdef IMEM_ARB_PERF_EN
    logic [31:0]       perf_stall_cnt, perf_steal_cnt;
`endif

    imem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(8), .BOOT_HOLD(1)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_pc(core_pc), .core_gnt(core_gnt),
        .core_stall(core_stall), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata), .core_run(core_run),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_done(ldr_done), .ldr_boot(ldr_boot),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_steal_cnt(perf_steal_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: read-first, one cycle latency.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req = 1'b0; core_pc = 32'h0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = 32'h0;
        ldr_done = 1'b0; ldr_boot = 1'b0;
    endtask

    typedef struct {
        logic              core_req;
        logic [31:0]       core_pc;
        logic              ldr_req;
        logic              ldr_we;
        logic [ADDR_W-1:0] ldr_addr;
        logic [31:0]       ldr_wdata;
        logic              e_core_gnt;
        logic              e_ldr_gnt;
        logic              e_mem_en;
        logic              e_mem_we;
        logic [ADDR_W-1:0] e_mem_addr;
        logic              e_core_rvalid;
        logic              e_ldr_rvalid;
        logic [31:0]       e_rdata;
    } vec_t;

    function automatic vec_t mk(
        input logic cr, input logic [31:0] pc, input logic lr, input logic lw,
        input logic [ADDR_W-1:0] la, input logic [31:0] ld,
        input logic cg, input logic lg, input logic en, input logic we,
        input logic [ADDR_W-1:0] ma, input logic crv, input logic lrv,
        input logic [31:0] rd);
        vec_t v;
        v.core_req = cr; v.core_pc = pc; v.ldr_req = lr; v.ldr_we = lw;
        v.ldr_addr = la; v.ldr_wdata = ld;
        v.e_core_gnt = cg; v.e_ldr_gnt = lg; v.e_mem_en = en; v.e_mem_we = we;
        v.e_mem_addr = ma; v.e_core_rvalid = crv; v.e_ldr_rvalid = lrv;
        v.e_rdata = rd;
        return v;
    endfunction

    vec_t vecs [13];
    int   gnt_cycle;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Run-mode vectors, applied one per cycle straight after boot.
        //              creq pc            lreq lwe laddr ldata         cg lg en we maddr crv lrv rdata
        vecs[0]  = mk(1, 32'h0000_0000, 0, 0, 12'd0,  32'h0,         1, 0, 1, 0, 12'd0,  0, 0, 32'h0);
        vecs[1]  = mk(1, 32'h0000_0004, 0, 0, 12'd0,  32'h0,         1, 0, 1, 0, 12'd1,  1, 0, 32'hA000_0000);
        vecs[2]  = mk(1, 32'h0000_0008, 0, 0, 12'd0,  32'h0,         1, 0, 1, 0, 12'd2,  1, 0, 32'hA000_0001);
        vecs[3]  = mk(1, 32'h0000_400F, 0, 0, 12'd0,  32'h0,         1, 0, 1, 0, 12'd3,  1, 0, 32'hA000_0002);
        vecs[4]  = mk(0, 32'h0000_0000, 0, 0, 12'd0,  32'h0,         0, 0, 0, 0, 12'd0,  1, 0, 32'hA000_0003);
        vecs[5]  = mk(0, 32'h0000_0000, 1, 0, 12'd7,  32'h0,         0, 1, 1, 0, 12'd7,  0, 0, 32'h0);
        vecs[6]  = mk(0, 32'h0000_0000, 0, 0, 12'd0,  32'h0,         0, 0, 0, 0, 12'd0,  0, 1, 32'hA000_0007);
        vecs[7]  = mk(0, 32'h0000_0000, 1, 1, 12'd20, 32'h1234_5678, 0, 1, 1, 1, 12'd20, 0, 0, 32'h0);
        vecs[8]  = mk(1, 32'h0000_0050, 0, 0, 12'd0,  32'h0,         1, 0, 1, 0, 12'd20, 0, 0, 32'h0);
        vecs[9]  = mk(0, 32'h0000_0000, 0, 0, 12'd0,  32'h0,         0, 0, 0, 0, 12'd0,  1, 0, 32'h1234_5678);
        vecs[10] = mk(1, 32'h0000_0004, 1, 0, 12'd9,  32'h0,         1, 0, 1, 0, 12'd1,  0, 0, 32'h0);
        vecs[11] = mk(0, 32'h0000_0000, 1, 0, 12'd9,  32'h0,         0, 1, 1, 0, 12'd9,  1, 0, 32'hA000_0001);
        vecs[12] = mk(0, 32'h0000_0000, 0, 0, 12'd0,  32'h0,         0, 0, 0, 0, 12'd0,  0, 1, 32'hA000_0009);

        // ---------------- reset ----------------
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        check("reset core_run",    32'(core_run),    32'd0);
        check("reset core_rvalid", 32'(core_rvalid), 32'd0);
        check("reset ldr_rvalid",  32'(ldr_rvalid),  32'd0);
        check("reset mem_en",      32'(mem_en),      32'd0);
        check("reset mem_addr",    32'(mem_addr),    32'd0);
        rst = 1'b0;

        // ---------------- boot load ----------------
        for (int i = 0; i < 16; i++) begin
            core_req  = 1'b1;
            core_pc   = 32'h0;
            ldr_req   = 1'b1;
            ldr_we    = 1'b1;
            ldr_addr  = ADDR_W'(i);
            ldr_wdata = 32'hA000_0000 + 32'(i);
            ldr_done  = (i == 15);   // done coincides with the final write
            #1;
            check($sformatf("boot[%0d] ldr_gnt", i),    32'(ldr_gnt),    32'd1);
            check($sformatf("boot[%0d] core_gnt", i),   32'(core_gnt),   32'd0);
            check($sformatf("boot[%0d] core_stall", i), 32'(core_stall), 32'd1);
            check($sformatf("boot[%0d] core_run", i),   32'(core_run),   32'd0);
            check($sformatf("boot[%0d] mem_we", i),     32'(mem_we),     32'd1);
            check($sformatf("boot[%0d] mem_addr", i),   32'(mem_addr),   32'(i));
            check($sformatf("boot[%0d] ldr_rvalid", i), 32'(ldr_rvalid), 32'd0);
            cyc();
        end
        idle_inputs();
        check("after done core_run", 32'(core_run), 32'd1);

        // ---------------- run-mode vector table ----------------
        for (int k = 0; k < 13; k++) begin
            core_req  = vecs[k].core_req;
            core_pc   = vecs[k].core_pc;
            ldr_req   = vecs[k].ldr_req;
            ldr_we    = vecs[k].ldr_we;
            ldr_addr  = vecs[k].ldr_addr;
            ldr_wdata = vecs[k].ldr_wdata;
            #1;
            check($sformatf("vec[%0d] core_gnt", k),    32'(core_gnt),    32'(vecs[k].e_core_gnt));
            check($sformatf("vec[%0d] ldr_gnt", k),     32'(ldr_gnt),     32'(vecs[k].e_ldr_gnt));
            check($sformatf("vec[%0d] core_stall", k),  32'(core_stall),
                  32'(vecs[k].core_req & ~vecs[k].e_core_gnt));
            check($sformatf("vec[%0d] mem_en", k),      32'(mem_en),      32'(vecs[k].e_mem_en));
            check($sformatf("vec[%0d] mem_we", k),      32'(mem_we),      32'(vecs[k].e_mem_we));
            check($sformatf("vec[%0d] mem_addr", k),    32'(mem_addr),    32'(vecs[k].e_mem_addr));
            check($sformatf("vec[%0d] core_rvalid", k), 32'(core_rvalid), 32'(vecs[k].e_core_rvalid));
            check($sformatf("vec[%0d] ldr_rvalid", k),  32'(ldr_rvalid),  32'(vecs[k].e_ldr_rvalid));
            if (vecs[k].e_core_rvalid)
                check($sformatf("vec[%0d] core_rdata", k), core_rdata, vecs[k].e_rdata);
            if (vecs[k].e_ldr_rvalid)
                check($sformatf("vec[%0d] ldr_rdata", k), ldr_rdata, vecs[k].e_rdata);
            cyc();
        end
        idle_inputs();

        // ---------------- starvation bound ----------------
        core_req = 1'b1;
        core_pc  = 32'h10;
        ldr_req  = 1'b1;
        ldr_we   = 1'b0;
        ldr_addr = 12'd5;
        gnt_cycle = 0;
        for (int c = 1; c <= 20 && gnt_cycle == 0; c++) begin
            #1;
            if (ldr_gnt) begin
                gnt_cycle = c;
                check("starve core_gnt",   32'(core_gnt),   32'd0);
                check("starve core_stall", 32'(core_stall), 32'd1);
                check("starve mem_addr",   32'(mem_addr),   32'd5);
            end else if (c == 1) begin
                check("starve core first", 32'(core_gnt), 32'd1);
            end
            cyc();
        end
        check("starve grant cycle", 32'(gnt_cycle), 32'd9);
        ldr_req = 1'b0;
        #1;
        check("starve ldr_rvalid", 32'(ldr_rvalid), 32'd1);
        check("starve ldr_rdata",  ldr_rdata,       32'hA000_0005);
        check("starve core back",  32'(core_gnt),   32'd1);
        cyc();
        // Wait counter cleared by the grant: a fresh request loses to the core.
        ldr_req = 1'b1;
        #1;
        check("wait cleared core_gnt", 32'(core_gnt), 32'd1);
        check("wait cleared ldr_gnt",  32'(ldr_gnt),  32'd0);
        cyc();
        idle_inputs();
`ifdef IMEM_ARB_PERF_EN
        check("perf_stall_cnt", perf_stall_cnt, 32'd1);
        check("perf_steal_cnt", perf_steal_cnt, 32'd1);
`endif

        // ---------------- reload: ldr_boot beats ldr_done ----------------
        ldr_boot = 1'b1;
        ldr_done = 1'b1;
        #1;
        check("reload core_run before", 32'(core_run), 32'd1);
        cyc();
        idle_inputs();
        core_req = 1'b1;
        #1;
        check("reload core_run after", 32'(core_run),   32'd0);
        check("reload core_gnt",       32'(core_gnt),   32'd0);
        check("reload core_stall",     32'(core_stall), 32'd1);
        ldr_done = 1'b1;
        cyc();
        idle_inputs();
        check("rerun core_run", 32'(core_run), 32'd1);

        // ---------------- reset the cycle after a core grant ----------------
        core_req = 1'b1;
        core_pc  = 32'h0;
        ldr_req  = 1'b1;
        ldr_addr = 12'd2;
        #1;
        check("rst seq core_gnt", 32'(core_gnt), 32'd1);
        cyc();
        idle_inputs();
        rst = 1'b1;
        #1;
        check("rst seq rvalid in flight", 32'(core_rvalid), 32'd1);
        cyc();
        rst = 1'b0;
        #1;
        check("rst seq core_rvalid", 32'(core_rvalid), 32'd0);
        check("rst seq core_run",    32'(core_run),    32'd0);

        // Reset on the same cycle as a grant drops that read.
        ldr_done = 1'b1;
        cyc();
        idle_inputs();
        core_req = 1'b1;
        rst = 1'b1;
        #1;
        check("rst same core_gnt", 32'(core_gnt), 32'd1);
        cyc();
        rst = 1'b0;
        idle_inputs();
        #1;
        check("rst same core_rvalid", 32'(core_rvalid), 32'd0);
        check("rst same core_run",    32'(core_run),    32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
